vec_mc_fifo: RTL and testbench
==============================

VEC_MC_FIFO -- requirements
Module: vec_mc_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 248, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entries per channel; power of 2, at least 2.
REQ-003 SHALL have parameter NUM_CH, default 4, independent channels; power of 2, at least 1; CHW = max(1, clog2(NUM_CH)), AW = clog2(DEPTH).
REQ-004 SHALL have parameter AF_LVL, default DEPTH-2, almost-full threshold (count >= AF_LVL).
REQ-005 SHALL have parameter AE_LVL, default 2, almost-empty threshold (count <= AE_LVL).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 i_write  in  1  write request; i_wr_ch  in  CHW  write channel; i_data  in  WIDTH  write data.
REQ-009 i_read  in  1  read request; i_rd_ch  in  CHW  read channel.
REQ-010 o_data  out  WIDTH  registered read data; o_valid  out  1  o_data valid pulse; o_rd_ch  out  CHW  channel of o_data.
REQ-011 i_flush  in  NUM_CH  per-channel flush; i_clr_err  in  1  clears sticky error flags.
REQ-012 o_full, o_empty, o_almost_full, o_almost_empty  out  NUM_CH each  per-channel status, combinational from current state.
REQ-013 o_count  out  NUM_CH*(AW+1)  per-channel occupancy 0..DEPTH, channel c at bits [c*(AW+1) +: AW+1].
REQ-014 o_overflow, o_underflow  out  NUM_CH each  sticky per-channel error flags.

Function
REQ-015 Storage SHALL be one array of NUM_CH*DEPTH words, addressed {channel, pointer[AW-1:0]}.
REQ-016 Each channel SHALL keep AW+1-bit read/write pointers; empty = pointers equal; full = low AW bits equal and MSBs differ; count = wr - rd (mod 2^(AW+1)).
REQ-017 Write accepted iff i_write and channel not full (pre-edge state) and i_flush[i_wr_ch] low; word stored, wr pointer +1, wrapping naturally.
REQ-018 Read accepted iff i_read and channel not empty (pre-edge state) and i_flush[i_rd_ch] low; rd pointer +1.
REQ-019 Read latency SHALL be 1 cycle: accepted read at edge N drives o_data, o_rd_ch and o_valid=1 after edge N; o_valid=0 otherwise; o_data holds last value when o_valid=0.
REQ-020 Write to a full channel SHALL be dropped and set o_overflow[ch]; read from an empty channel SHALL be dropped, o_valid=0, and set o_underflow[ch].
REQ-021 Simultaneous read and write, same full channel: read accepted, write dropped, overflow set. Same empty channel: write accepted, read dropped, underflow set; the written word is readable next cycle.
REQ-022 Simultaneous read and write, same non-full non-empty channel: both accepted, count unchanged.
REQ-023 i_flush[c] SHALL reset channel c pointers to 0 at next edge; flush wins over same-cycle read/write to c without setting error flags; other channels unaffected.
REQ-024 i_clr_err SHALL clear all error flags at next edge; an error in the same cycle SHALL win (flag stays set).
REQ-025 Almost-full/almost-empty SHALL follow REQ-004/005 from o_count; full implies almost-full, empty implies almost-empty.

Reset
REQ-026 On rst: all pointers 0, o_valid 0, o_data 0, o_rd_ch 0, o_overflow/o_underflow 0; hence o_empty all 1, o_full all 0, o_count all 0, o_almost_empty all 1.
REQ-027 Memory contents SHALL NOT be reset; rst mid-operation discards all queued data and any read in flight (o_valid 0 after the reset edge).

Structure
REQ-028 Package simd_fifo_pkg SHALL hold default WIDTH/DEPTH/NUM_CH constants and the per-channel status struct typedef (full, empty, almost_full, almost_empty, count).
REQ-029 Per-channel pointer/flag/count logic SHALL be sub-module fifo_ch_ctrl, instantiated NUM_CH times via generate; storage and read register stay in vec_mc_fifo.

Verification
REQ-030 Reset, then write 0xA1,0xA2,0xA3 to ch2, read ch2 x3 -> o_valid 1 each following cycle with 0xA1,0xA2,0xA3, o_rd_ch=2; ch2 empty after.
REQ-031 Write 16 words to ch0 (DEPTH=16) -> o_full[0]=1, o_count ch0=16, o_almost_full[0] from count 14; 17th write -> dropped, o_overflow[0]=1, others 0.
REQ-032 Read empty ch1 -> o_valid 0, o_underflow[1]=1; i_clr_err -> cleared next cycle.
REQ-033 ch3 empty, write 0x55 and read ch3 same cycle -> read dropped, underflow[3]=1; read next cycle -> 0x55.
REQ-034 Fill ch1 with 5 words, 40 write/read pairs on ch1 (pointer wrap) -> count stays 5, data in order; then i_flush[1] with write -> ch1 count 0, no error flags.
REQ-035 ch0 holds 3 words, assert rst with pending read -> o_valid 0 after edge, all channels empty, count 0.

Source files
------------

// File: rtl/simd_fifo_pkg.sv
// Shared defaults and per-channel status payload for the multi-channel FIFO.
package simd_fifo_pkg;

    localparam int unsigned DEF_WIDTH  = 248;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_NUM_CH = 4;

    // Wide enough for any practical DEPTH; users take the low AW+1 bits.
    localparam int unsigned ST_CNT_W = 16;

    typedef struct packed {
        logic                full;
        logic                empty;
        logic                almost_full;
        logic                almost_empty;
        logic [ST_CNT_W-1:0] count;
    } ch_status_t;

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Pointer, occupancy and sticky error tracking for one FIFO channel.
module fifo_ch_ctrl
    import simd_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_write,
    input  logic                         i_read,
    input  logic                         i_flush,
    input  logic                         i_clr_err,
    output logic                         o_wr_acc_c,
    output logic                         o_rd_acc_c,
    output logic [$clog2(DEPTH)-1:0]     o_wr_addr,
    output logic [$clog2(DEPTH)-1:0]     o_rd_addr,
    output ch_status_t                   o_status_c,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_ovf_set;
    logic        w_unf_set;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_count   = r_wr_ptr - r_rd_ptr;

    // Flush suppresses both the transfer and any error it would have raised.
    assign o_wr_acc_c = i_write && !w_full  && !i_flush;
    assign o_rd_acc_c = i_read  && !w_empty && !i_flush;
    assign w_ovf_set  = i_write && w_full   && !i_flush;
    assign w_unf_set  = i_read  && w_empty  && !i_flush;

    assign o_wr_addr = r_wr_ptr[AW-1:0];
    assign o_rd_addr = r_rd_ptr[AW-1:0];

    always_comb begin
        o_status_c              = '0;
        o_status_c.full         = w_full;
        o_status_c.empty        = w_empty;
        o_status_c.almost_full  = (32'(w_count) >= AF_LVL);
        o_status_c.almost_empty = (32'(w_count) <= AE_LVL);
        o_status_c.count        = ST_CNT_W'(w_count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (o_wr_acc_c) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (o_rd_acc_c) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            // A new error in the clearing cycle keeps its flag set.
            o_overflow  <= (o_overflow  && !i_clr_err) || w_ovf_set;
            o_underflow <= (o_underflow && !i_clr_err) || w_unf_set;
        end
    end

endmodule

// File: rtl/vec_mc_fifo.sv
// Multi-channel FIFO: shared storage array, per-channel controllers, registered read port.
module vec_mc_fifo
    import simd_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2,
    localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_write,
    input  logic [CHW-1:0]           i_wr_ch,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_read,
    input  logic [CHW-1:0]           i_rd_ch,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [CHW-1:0]           o_rd_ch,
    input  logic [NUM_CH-1:0]        i_flush,
    input  logic                     i_clr_err,
    output logic [NUM_CH-1:0]        o_full,
    output logic [NUM_CH-1:0]        o_empty,
    output logic [NUM_CH-1:0]        o_almost_full,
    output logic [NUM_CH-1:0]        o_almost_empty,
    output logic [NUM_CH*(AW+1)-1:0] o_count,
    output logic [NUM_CH-1:0]        o_overflow,
    output logic [NUM_CH-1:0]        o_underflow
);

    localparam int unsigned MAW = $clog2(NUM_CH * DEPTH);

    logic [WIDTH-1:0]  r_mem [NUM_CH*DEPTH];
    logic [NUM_CH-1:0] w_wr_acc;
    logic [NUM_CH-1:0] w_rd_acc;
    logic [AW-1:0]     w_wr_addr [NUM_CH];
    logic [AW-1:0]     w_rd_addr [NUM_CH];
    ch_status_t        w_status  [NUM_CH];
    logic [MAW-1:0]    w_mem_wa;
    logic [MAW-1:0]    w_mem_ra;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_ch_ctrl #(
            .DEPTH  (DEPTH),
            .AF_LVL (AF_LVL),
            .AE_LVL (AE_LVL)
        ) u_ctrl (
            .clk         (clk),
            .rst         (rst),
            .i_write     (i_write && (i_wr_ch == CHW'(c))),
            .i_read      (i_read  && (i_rd_ch == CHW'(c))),
            .i_flush     (i_flush[c]),
            .i_clr_err   (i_clr_err),
            .o_wr_acc_c  (w_wr_acc[c]),
            .o_rd_acc_c  (w_rd_acc[c]),
            .o_wr_addr   (w_wr_addr[c]),
            .o_rd_addr   (w_rd_addr[c]),
            .o_status_c  (w_status[c]),
            .o_overflow  (o_overflow[c]),
            .o_underflow (o_underflow[c])
        );

        assign o_full[c]                   = w_status[c].full;
        assign o_empty[c]                  = w_status[c].empty;
        assign o_almost_full[c]            = w_status[c].almost_full;
        assign o_almost_empty[c]           = w_status[c].almost_empty;
        assign o_count[c*(AW+1) +: AW+1]   = (AW+1)'(w_status[c].count);
    end

    // Storage address is {channel, pointer}; the channel field vanishes when NUM_CH is 1.
    assign w_mem_wa = MAW'({i_wr_ch, w_wr_addr[i_wr_ch]});
    assign w_mem_ra = MAW'({i_rd_ch, w_rd_addr[i_rd_ch]});

    always_ff @(posedge clk) begin
        if (|w_wr_acc) r_mem[w_mem_wa] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_rd_ch <= '0;
        end else begin
            o_valid <= |w_rd_acc;
            if (|w_rd_acc) begin
                o_data  <= r_mem[w_mem_ra];
                o_rd_ch <= i_rd_ch;
            end
        end
    end

endmodule

// File: tb/tb_vec_mc_fifo.sv
// Scoreboard bench for vec_mc_fifo with default parameters.
module tb_vec_mc_fifo;

    localparam int unsigned WIDTH  = 248;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CHW    = 2;
    localparam int unsigned AW     = 4;

    typedef struct {
        logic [CHW-1:0]   ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     i_write;
    logic [CHW-1:0]           i_wr_ch;
    logic [WIDTH-1:0]         i_data;
    logic                     i_read;
    logic [CHW-1:0]           i_rd_ch;
    logic [WIDTH-1:0]         o_data;
    logic                     o_valid;
    logic [CHW-1:0]           o_rd_ch;
    logic [NUM_CH-1:0]        i_flush;
    logic                     i_clr_err;
    logic [NUM_CH-1:0]        o_full;
    logic [NUM_CH-1:0]        o_empty;
    logic [NUM_CH-1:0]        o_almost_full;
    logic [NUM_CH-1:0]        o_almost_empty;
    logic [NUM_CH*(AW+1)-1:0] o_count;
    logic [NUM_CH-1:0]        o_overflow;
    logic [NUM_CH-1:0]        o_underflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    vec_mc_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .i_write        (i_write),
        .i_wr_ch        (i_wr_ch),
        .i_data         (i_data),
        .i_read         (i_read),
        .i_rd_ch        (i_rd_ch),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_rd_ch        (o_rd_ch),
        .i_flush        (i_flush),
        .i_clr_err      (i_clr_err),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW:0] cnt(input int c);
        return o_count[c*(AW+1) +: AW+1];
    endfunction

    // Monitor: every o_valid must match the oldest expected read.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got ch %0d data 0x%0h, none expected", o_rd_ch, o_data[63:0]);
            end else begin
                e = sb_q.pop_front();
                if (o_data !== e.data || o_rd_ch !== e.ch) begin
                    errors++;
                    $display("FAIL read_data: got ch %0d data 0x%0h expected ch %0d data 0x%0h",
                             o_rd_ch, o_data[63:0], e.ch, e.data[63:0]);
                end
            end
        end
    end

    task automatic idle();
        i_write   = 1'b0;
        i_wr_ch   = '0;
        i_data    = '0;
        i_read    = 1'b0;
        i_rd_ch   = '0;
        i_flush   = '0;
        i_clr_err = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int ch, input logic [WIDTH-1:0] d);
        i_write = 1'b1;
        i_wr_ch = CHW'(ch);
        i_data  = d;
        cyc();
    endtask

    // Read; push an expectation only when the read should be accepted.
    task automatic rd(input int ch, input bit expect_data, input logic [WIDTH-1:0] d);
        exp_t e;
        i_read  = 1'b1;
        i_rd_ch = CHW'(ch);
        if (expect_data) begin
            e.ch   = CHW'(ch);
            e.data = d;
            sb_q.push_back(e);
        end
        cyc();
    endtask

    task automatic clr_err();
        i_clr_err = 1'b1;
        cyc();
    endtask

    initial begin
        logic [WIDTH-1:0] mdl[$];
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        check("rst_valid",  64'(o_valid), 64'h0);
        check("rst_data",   o_data[63:0], 64'h0);
        check("rst_empty",  64'(o_empty), 64'hf);
        check("rst_full",   64'(o_full), 64'h0);
        check("rst_count",  64'(o_count), 64'h0);
        check("rst_ae",     64'(o_almost_empty), 64'hf);
        check("rst_errs",   64'({o_overflow, o_underflow}), 64'h0);

        // Basic ordering on ch2
        wr(2, 'hA1); wr(2, 'hA2); wr(2, 'hA3);
        check("ch2_count3", 64'(cnt(2)), 64'd3);
        rd(2, 1, 'hA1); rd(2, 1, 'hA2); rd(2, 1, 'hA3);
        cyc();
        check("ch2_empty", 64'(o_empty[2]), 64'h1);

        // Fill ch0 to full, then overflow
        for (int i = 0; i < 16; i++) begin
            wr(0, WIDTH'(32'h1000 + i));
            if (i == 12) check("ch0_af_at13", 64'(o_almost_full[0]), 64'h0);
            if (i == 13) check("ch0_af_at14", 64'(o_almost_full[0]), 64'h1);
        end
        check("ch0_full",   64'(o_full), 64'h1);
        check("ch0_count",  64'(cnt(0)), 64'd16);
        wr(0, 'hDEAD);
        check("ch0_ovf",    64'(o_overflow), 64'h1);
        check("ch0_unf",    64'(o_underflow), 64'h0);
        check("ch0_count_after_drop", 64'(cnt(0)), 64'd16);
        for (int i = 0; i < 16; i++) rd(0, 1, WIDTH'(32'h1000 + i));
        check("ch0_drained", 64'(o_empty[0]), 64'h1);
        clr_err();
        check("ovf_cleared", 64'(o_overflow), 64'h0);

        // Underflow on ch1
        rd(1, 0, '0);
        check("ch1_unf", 64'(o_underflow), 64'h2);
        clr_err();
        check("unf_cleared", 64'(o_underflow), 64'h0);

        // Clear and a new error in the same cycle: error wins
        rd(1, 0, '0);
        i_clr_err = 1'b1; i_read = 1'b1; i_rd_ch = 2'd1;
        cyc();
        check("clr_vs_err", 64'(o_underflow), 64'h2);
        clr_err();

        // Simultaneous write and read on empty ch3
        i_write = 1'b1; i_wr_ch = 2'd3; i_data = 'h55;
        i_read  = 1'b1; i_rd_ch = 2'd3;
        cyc();
        check("ch3_unf",   64'(o_underflow), 64'h8);
        check("ch3_count", 64'(cnt(3)), 64'd1);
        rd(3, 1, 'h55);
        clr_err();

        // ch1 steady-state traffic across pointer wrap
        for (int i = 0; i < 5; i++) begin
            wr(1, WIDTH'(32'h100 + i));
            mdl.push_back(WIDTH'(32'h100 + i));
        end
        for (int k = 0; k < 40; k++) begin
            exp_t e;
            i_write = 1'b1; i_wr_ch = 2'd1; i_data = WIDTH'(32'h200 + k);
            i_read  = 1'b1; i_rd_ch = 2'd1;
            e.ch   = 2'd1;
            e.data = mdl.pop_front();
            sb_q.push_back(e);
            mdl.push_back(WIDTH'(32'h200 + k));
            cyc();
        end
        check("ch1_count_steady", 64'(cnt(1)), 64'd5);
        wr(3, 'h77);
        i_flush = 4'b0010; i_write = 1'b1; i_wr_ch = 2'd1; i_data = 'h999;
        cyc();
        check("ch1_flushed",   64'(cnt(1)), 64'd0);
        check("flush_no_errs", 64'({o_overflow, o_underflow}), 64'h0);
        check("ch3_untouched", 64'(cnt(3)), 64'd1);

        // Reset with a read in flight on ch0
        wr(0, 'h31); wr(0, 'h32); wr(0, 'h33);
        check("ch0_count3", 64'(cnt(0)), 64'd3);
        rst = 1'b1; i_read = 1'b1; i_rd_ch = 2'd0;
        cyc();
        rst = 1'b0;
        check("rst2_valid", 64'(o_valid), 64'h0);
        check("rst2_empty", 64'(o_empty), 64'hf);
        check("rst2_count", 64'(o_count), 64'h0);

        cyc(); cyc();
        check("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
